// File: rtl/hazard_fwd_ctrl.sv
// Decode-stage hazard control: load-use and partial-lane stalls, EX operand forwarding selects, jump flush and end-of-program drain.
// Define HAZ_STATS_EN to build the saturating stall/flush event counters; otherwise both counter outputs are tied to zero.
module hazard_fwd_ctrl #(
   parameter int REG_AW = 3,
   parameter int LANES  = 2,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic [LANES-1:0]  id_rd_lanes,
   input  logic [REG_AW-1:0] id_dst,
   input  logic [LANES-1:0]  id_wr_lanes,
   input  logic              id_is_load,
   input  logic              id_jmp,
   input  logic              id_eop,
   output logic [1:0]        fwd_sel1,
   output logic [1:0]        fwd_sel2,
   output logic              stall,
   output logic              flush,
   output logic              halted,
   output logic              drained,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dst;
      logic [LANES-1:0]  wr_lanes;
      logic              is_load;
   } shadow_t;

   shadow_t    ex_q;
   shadow_t    mem_q;
   shadow_t    wb_q;
   logic       ex_m1;
   logic       ex_m2;
   logic       mem_m1;
   logic       mem_m2;
   logic       haz1;
   logic       haz2;
   logic       id_live;
   logic       accept;
   logic [1:0] sel1_d;
   logic [1:0] sel2_d;
   logic       wb_fields_unused;

   function automatic logic producer_match(input shadow_t s, input logic [REG_AW-1:0] src,
                                           input logic [LANES-1:0] rd);
      return s.valid && (s.dst == src) && ((s.wr_lanes & rd) != '0);
   endfunction

   // Only the youngest matching producer matters; WB is readable through the write-first register file.
   function automatic logic src_hazard(input logic ex_hit, input logic mem_hit, input shadow_t ex_s,
                                       input shadow_t mem_s, input logic [LANES-1:0] rd);
      logic h;
      h = 1'b0;
      if (ex_hit)
         h = ex_s.is_load || ((ex_s.wr_lanes & rd) != rd);
      else if (mem_hit)
         h = ((mem_s.wr_lanes & rd) != rd);
      return h;
   endfunction

   function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
      logic [1:0] s;
      s = 2'd0;
      if (ex_hit)
         s = 2'd1;
      else if (mem_hit)
         s = 2'd2;
      return s;
   endfunction

   // The instruction in decode during a flush cycle is wrong-path, and nothing is decoded once halted.
   always_comb begin
      ex_m1   = producer_match(ex_q, id_src1, id_rd_lanes);
      ex_m2   = producer_match(ex_q, id_src2, id_rd_lanes);
      mem_m1  = producer_match(mem_q, id_src1, id_rd_lanes);
      mem_m2  = producer_match(mem_q, id_src2, id_rd_lanes);
      haz1    = src_hazard(ex_m1, mem_m1, ex_q, mem_q, id_rd_lanes);
      haz2    = src_hazard(ex_m2, mem_m2, ex_q, mem_q, id_rd_lanes);
      id_live = id_valid && !halted && !flush;
      stall   = id_live && (haz1 || haz2);
      accept  = id_live && !stall;
      sel1_d  = fwd_pick(ex_m1, mem_m1);
      sel2_d  = fwd_pick(ex_m2, mem_m2);
   end

   // Shadow pipeline: EX takes the decoded instruction or a bubble, MEM and WB always advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         if (accept)
            ex_q <= {1'b1, id_dst, id_wr_lanes, id_is_load};
         else
            ex_q <= '0;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // Forwarding selects follow the instruction into EX; jump and end-of-program act only on accepted instructions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_sel1 <= 2'd0;
         fwd_sel2 <= 2'd0;
         flush    <= 1'b0;
         halted   <= 1'b0;
      end else begin
         fwd_sel1 <= accept ? sel1_d : 2'd0;
         fwd_sel2 <= accept ? sel2_d : 2'd0;
         flush    <= accept && id_jmp;
         halted   <= halted || (accept && id_eop);
      end
   end

   assign drained = halted && !(ex_q.valid || mem_q.valid || wb_q.valid);

   assign wb_fields_unused = ^{wb_q.dst, wb_q.wr_lanes, wb_q.is_load};

`ifdef HAZ_STATS_EN
   localparam logic [STAT_W-1:0] CNT_ONE = STAT_W'(1);

   // Event counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed pipeline scenarios plus randomized traffic against an in-flight-list model.
module tb_hazard_fwd_ctrl;

   localparam int REG_AW  = 3;
   localparam int LANES   = 2;
   localparam int STAT_W  = 4;
   localparam int CNT_MAX = (1 << STAT_W) - 1;
`ifdef HAZ_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] id_src1 = '0;
   logic [REG_AW-1:0] id_src2 = '0;
   logic [LANES-1:0]  id_rd_lanes = '0;
   logic [REG_AW-1:0] id_dst = '0;
   logic [LANES-1:0]  id_wr_lanes = '0;
   logic              id_is_load = 1'b0;
   logic              id_jmp = 1'b0;
   logic              id_eop = 1'b0;
   logic [1:0]        fwd_sel1;
   logic [1:0]        fwd_sel2;
   logic              stall;
   logic              flush;
   logic              halted;
   logic              drained;
   logic [STAT_W-1:0] stall_cnt;
   logic [STAT_W-1:0] flush_cnt;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.REG_AW(REG_AW), .LANES(LANES), .STAT_W(STAT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_rd_lanes(id_rd_lanes), .id_dst(id_dst), .id_wr_lanes(id_wr_lanes), .id_is_load(id_is_load),
      .id_jmp(id_jmp), .id_eop(id_eop), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall(stall),
      .flush(flush), .halted(halted), .drained(drained), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Model: list of instructions issued into EX, youngest first, three deep.
   typedef struct {
      bit v;
      int dst;
      int lanes;
      bit load;
   } ins_t;

   ins_t pipe[$];
   bit   m_flush;
   bit   m_halted;
   int   m_sel1;
   int   m_sel2;
   int   m_scnt;
   int   m_fcnt;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic int youngest_producer(input int src, input int rd);
      for (int age = 0; age < 2; age++)
         if (pipe[age].v && pipe[age].dst == src && (pipe[age].lanes & rd) != 0)
            return age;
      return -1;
   endfunction

   function automatic bit source_blocked(input int src, input int rd);
      int age;
      age = youngest_producer(src, rd);
      if (age < 0) return 1'b0;
      if (age == 0 && pipe[0].load) return 1'b1;
      return (pipe[age].lanes & rd) != rd;
   endfunction

   function automatic bit exp_live();
      return id_valid && !m_halted && !m_flush;
   endfunction

   function automatic bit exp_stall();
      return exp_live() && (source_blocked(int'(id_src1), int'(id_rd_lanes)) ||
                            source_blocked(int'(id_src2), int'(id_rd_lanes)));
   endfunction

   function automatic bit exp_drained();
      if (!m_halted) return 1'b0;
      foreach (pipe[i]) if (pipe[i].v) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exp_cnt(input int c);
      return STATS_ON ? c : 0;
   endfunction

   task automatic model_clear();
      ins_t empty;
      empty = '{v: 1'b0, dst: 0, lanes: 0, load: 1'b0};
      pipe.delete();
      repeat (3) pipe.push_back(empty);
      m_flush = 0; m_halted = 0; m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   // Advance the model by the cycle whose inputs are currently applied, then let the DUT take the edge.
   task automatic tick();
      bit   stall_now;
      bit   take;
      ins_t entry;
      stall_now = exp_stall();
      take = exp_live() && !stall_now;
      if (stall_now && m_scnt < CNT_MAX) m_scnt++;
      if (m_flush && m_fcnt < CNT_MAX) m_fcnt++;
      m_sel1 = take ? youngest_producer(int'(id_src1), int'(id_rd_lanes)) + 1 : 0;
      m_sel2 = take ? youngest_producer(int'(id_src2), int'(id_rd_lanes)) + 1 : 0;
      m_halted = m_halted || (take && id_eop);
      m_flush = take && id_jmp;
      entry = '{v: take, dst: int'(id_dst), lanes: int'(id_wr_lanes), load: id_is_load};
      pipe.push_front(entry);
      void'(pipe.pop_back());
      @(posedge clk);
   endtask

   task automatic drive(input bit v, input int s1, input int s2, input int rd, input int dst,
                        input int wr, input bit ld, input bit jmp, input bit eop);
      @(negedge clk);
      id_valid = v; id_src1 = 3'(s1); id_src2 = 3'(s2); id_rd_lanes = 2'(rd);
      id_dst = 3'(dst); id_wr_lanes = 2'(wr); id_is_load = ld; id_jmp = jmp; id_eop = eop;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic assert_reset();
      @(negedge clk);
      rst_n = 1'b0;
      id_valid = 0; id_src1 = '0; id_src2 = '0; id_rd_lanes = '0; id_dst = '0;
      id_wr_lanes = '0; id_is_load = 0; id_jmp = 0; id_eop = 0;
      model_clear();
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      assert_reset();
      vectors++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_sel1, fwd_sel2); end
      vectors++; if (flush !== 1'b0 || halted !== 1'b0 || drained !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got flush=%b halted=%b drained=%b stall=%b expected all 0", flush, halted, drained, stall); end
      vectors++; if (stall_cnt !== '0 || flush_cnt !== '0) begin miscompares++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
      release_reset();
   endtask

   task automatic test_fwd_ex();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 1, 3, 0, 0, 0); tick();
      drive(1, 1, 0, 3, 5, 3, 0, 0, 0);
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL fwd_ex_stall: got %b expected 0", stall); end
      tick();
      idle();
      vectors++; if (fwd_sel1 !== 2'd1) begin miscompares++; $display("[TB] FAIL fwd_ex_sel1: got %0d expected 1", fwd_sel1); end
      vectors++; if (fwd_sel2 !== 2'd0) begin miscompares++; $display("[TB] FAIL fwd_ex_sel2: got %0d expected 0", fwd_sel2); end
      tick();
   endtask

   task automatic test_load_use();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 2, 3, 1, 0, 0); tick();
      drive(1, 2, 0, 3, 5, 3, 0, 0, 0);
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL load_use_stall: got %b expected 1", stall); end
      tick();
      drive(1, 2, 0, 3, 5, 3, 0, 0, 0);
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL load_use_release: got %b expected 0", stall); end
      vectors++; if (fwd_sel1 !== 2'd0) begin miscompares++; $display("[TB] FAIL load_use_bubble_sel: got %0d expected 0", fwd_sel1); end
      tick();
      idle();
      vectors++; if (fwd_sel1 !== 2'd2) begin miscompares++; $display("[TB] FAIL load_use_sel_mem: got %0d expected 2", fwd_sel1); end
      vectors++; if (stall_cnt !== STAT_W'(exp_cnt(1))) begin miscompares++; $display("[TB] FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt(1)); end
      tick();
   endtask

   task automatic test_partial_lanes();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 3, 0, 3, 5, 3, 0, 0, 0);
         vectors++; if (stall !== (i < 2)) begin miscompares++; $display("[TB] FAIL partial_stall_c%0d: got %b expected %b", i, stall, i < 2); end
         tick();
      end
      idle();
      vectors++; if (fwd_sel1 !== 2'd0) begin miscompares++; $display("[TB] FAIL partial_sel: got %0d expected 0", fwd_sel1); end
      vectors++; if (stall_cnt !== STAT_W'(exp_cnt(2))) begin miscompares++; $display("[TB] FAIL partial_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt(2)); end
      tick();
   endtask

   task automatic test_jmp_flush();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL jmp_flush_early: got %b expected 0", flush); end
      tick();
      drive(1, 0, 0, 0, 6, 3, 0, 0, 0);
      vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL jmp_flush_pulse: got %b expected 1", flush); end
      tick();
      drive(1, 6, 0, 3, 0, 0, 0, 0, 0);
      vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL jmp_flush_single: got %b expected 0", flush); end
      vectors++; if (flush_cnt !== STAT_W'(exp_cnt(1))) begin miscompares++; $display("[TB] FAIL jmp_flush_cnt1: got %0d expected %0d", flush_cnt, exp_cnt(1)); end
      tick();
      drive(1, 0, 0, 0, 2, 3, 1, 0, 0);
      vectors++; if (fwd_sel1 !== 2'd0) begin miscompares++; $display("[TB] FAIL jmp_killed_fwd: got %0d expected 0", fwd_sel1); end
      tick();
      drive(1, 2, 0, 3, 0, 0, 0, 1, 0);
      vectors++; if (stall !== 1'b1 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL jmp_in_stall: got stall=%b flush=%b expected 1/0", stall, flush); end
      tick();
      drive(1, 2, 0, 3, 0, 0, 0, 1, 0);
      vectors++; if (stall !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL jmp_stall_release: got stall=%b flush=%b expected 0/0", stall, flush); end
      tick();
      idle();
      vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL jmp_delayed_flush: got %b expected 1", flush); end
      tick();
      idle();
      vectors++; if (flush !== 1'b0 || flush_cnt !== STAT_W'(exp_cnt(2))) begin miscompares++; $display("[TB] FAIL jmp_flush_cnt2: got flush=%b cnt=%0d expected 0/%0d", flush, flush_cnt, exp_cnt(2)); end
      tick();
   endtask

   task automatic test_eop_drain();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 1, 3, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 2, 3, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL eop_halt_early: got %b expected 0", halted); end
      tick();
      idle();
      vectors++; if (halted !== 1'b1 || flush !== 1'b1 || drained !== 1'b0) begin miscompares++; $display("[TB] FAIL eop_jmp_both: got halted=%b flush=%b drained=%b expected 1/1/0", halted, flush, drained); end
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vectors++; if (drained !== 1'b0) begin miscompares++; $display("[TB] FAIL eop_drain_c2: got %b expected 0", drained); end
      tick();
      idle();
      vectors++; if (drained !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL eop_drain_c3: got drained=%b flush=%b expected 0/0", drained, flush); end
      tick();
      idle();
      vectors++; if (drained !== 1'b1 || halted !== 1'b1) begin miscompares++; $display("[TB] FAIL eop_drained: got drained=%b halted=%b expected 1/1", drained, halted); end
      tick();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 1, 3, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      idle();
      vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL eop_halt_again: got %b expected 1", halted); end
      tick();
      assert_reset();
      vectors++; if (halted !== 1'b0 || drained !== 1'b0) begin miscompares++; $display("[TB] FAIL eop_reset_mid_drain: got halted=%b drained=%b expected 0/0", halted, drained); end
      release_reset();
   endtask

   task automatic test_dual_youngest();
      assert_reset(); release_reset();
      drive(1, 0, 0, 0, 4, 3, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 4, 3, 0, 0, 0); tick();
      drive(1, 4, 4, 3, 7, 3, 0, 0, 0);
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL dual_stall: got %b expected 0", stall); end
      tick();
      idle();
      vectors++; if (fwd_sel1 !== 2'd1 || fwd_sel2 !== 2'd1) begin miscompares++; $display("[TB] FAIL dual_youngest: got %0d/%0d expected 1/1", fwd_sel1, fwd_sel2); end
      tick();
   endtask

   task automatic test_random();
      assert_reset(); release_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 150 == 149) begin
            assert_reset();
            vectors++; if (halted !== 1'b0 || drained !== 1'b0 || flush !== 1'b0 || fwd_sel1 !== 2'd0 || stall_cnt !== '0) begin miscompares++; $display("[TB] FAIL rand_reset c%0d: got halted=%b drained=%b flush=%b sel1=%0d scnt=%0d expected all 0", cyc, halted, drained, flush, fwd_sel1, stall_cnt); end
            release_reset();
         end
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
         vectors++; if (stall !== exp_stall()) begin miscompares++; $display("[TB] FAIL rand_stall c%0d: got %b expected %b", cyc, stall, exp_stall()); end
         vectors++; if (fwd_sel1 !== 2'(m_sel1) || fwd_sel2 !== 2'(m_sel2)) begin miscompares++; $display("[TB] FAIL rand_fwd c%0d: got %0d/%0d expected %0d/%0d", cyc, fwd_sel1, fwd_sel2, m_sel1, m_sel2); end
         vectors++; if (flush !== m_flush || halted !== m_halted) begin miscompares++; $display("[TB] FAIL rand_flush_halt c%0d: got %b/%b expected %b/%b", cyc, flush, halted, m_flush, m_halted); end
         vectors++; if (drained !== exp_drained()) begin miscompares++; $display("[TB] FAIL rand_drained c%0d: got %b expected %b", cyc, drained, exp_drained()); end
         vectors++; if (stall_cnt !== STAT_W'(exp_cnt(m_scnt)) || flush_cnt !== STAT_W'(exp_cnt(m_fcnt))) begin miscompares++; $display("[TB] FAIL rand_counters c%0d: got %0d/%0d expected %0d/%0d", cyc, stall_cnt, flush_cnt, exp_cnt(m_scnt), exp_cnt(m_fcnt)); end
         tick();
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_fwd_ex();
      test_load_use();
      test_partial_lanes();
      test_jmp_flush();
      test_eop_drain();
      test_dual_youngest();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
